regfile_mp: RTL

Parametrised successor to the core's 2-read/1-write integer register file. Provides NREAD synchronous read ports and one write port, with configurable width and depth and an optional r0-hardwired-zero mode. Adds a post-reset hardware clear sequencer with a busy flag. Sits in the decode/register-read stage; read data appears one cycle after address presentation, as before.

---
 rtl/regfile_mp.sv | 123 ++++++++++++
 1 files changed

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-read, single-write integer register file
// with a post-reset hardware clear sequencer.
//
// Optional feature macro: REGFILE_BYPASS_EN. When defined, a write and a read
// of the same register in one enabled cycle return the new write data
// (per read port). When undefined, the read returns the pre-write value.
//
// Ports:
//   clk       in   clock, all logic on rising edge
//   rst_n     in   synchronous active-low reset
//   en        in   stage enable; reads/writes only when en=1 and busy=0
//   writeEn   in   write request, qualified by en
//   rd        in   write address
//   dataDest  in   write data
//   rs        in   packed read addresses, port i = rs[i*ADDR_W +: ADDR_W]
//   data      out  packed registered read data, port i = data[i*XLEN +: XLEN]
//   busy      out  high while the clear sequencer runs
module regfile_mp #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NREAD    = 2,
    parameter int ZERO_REG = 1,
    parameter int ADDR_W   = $clog2(NREGS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    writeEn,
    input  logic [ADDR_W-1:0]       rd,
    input  logic [XLEN-1:0]         dataDest,
    input  logic [NREAD*ADDR_W-1:0] rs,
    output logic [NREAD*XLEN-1:0]   data,
    output logic                    busy
);

    typedef enum logic {CLEAR, RUN} state_t;

    // One extra bit so the index never wraps back onto register 0.
    localparam int CW = ADDR_W + 1;
    localparam logic [ADDR_W:0] LAST = CW'(NREGS - 1);

    state_t          state, state_nx;
    logic [ADDR_W:0] clr_idx, clr_idx_nx;
    logic [XLEN-1:0] regs [NREGS];
    logic            acc;
    logic            wr_ok;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= CLEAR;
            clr_idx <= '0;
        end else begin
            state   <= state_nx;
            clr_idx <= clr_idx_nx;
        end
    end

    // Next state / outputs
    always_comb begin
        state_nx   = state;
        clr_idx_nx = clr_idx;
        busy       = 1'b0;
        case (state)
            CLEAR: begin
                busy       = 1'b1;
                clr_idx_nx = clr_idx + CW'(1);
                if (clr_idx == LAST) state_nx = RUN;
            end
            RUN: begin
                busy = 1'b0;
            end
            default: begin
                state_nx = CLEAR;
                busy     = 1'b1;
            end
        endcase
    end

    assign acc   = en && (state == RUN);
    // Register 0 swallows writes when it is hardwired to zero.
    assign wr_ok = acc && writeEn && !((ZERO_REG != 0) && (rd == '0));

    // Storage: cleared by the sequencer, never by reset directly.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state == CLEAR)
                regs[clr_idx[ADDR_W-1:0]] <= '0;
            else if (wr_ok)
                regs[rd] <= dataDest;
        end
    end

    // Independent read ports
    for (genvar i = 0; i < NREAD; i++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [XLEN-1:0]   rv;
        logic [XLEN-1:0]   dq;

        assign ra = rs[i*ADDR_W +: ADDR_W];

        always_comb begin
            rv = regs[ra];
`ifdef REGFILE_BYPASS_EN
            if (writeEn && (rd == ra)) rv = dataDest;
`endif
            // Zero override last so it also wins over forwarding.
            if ((ZERO_REG != 0) && (ra == '0)) rv = '0;
        end

        always_ff @(posedge clk) begin
            if (!rst_n)
                dq <= '0;
            else if (state == CLEAR)
                dq <= '0;
            else if (acc)
                dq <= rv;
        end

        assign data[i*XLEN +: XLEN] = dq;
    end

endmodule
